// File: rtl/reg_write_arbiter.sv
`default_nettype none
// ============================================================================
// reg_write_arbiter : shares the register-file write port between pipeline
//                     write-back and mul/div results via a deferred-write FIFO
// Revision: 1.0
// ============================================================================
module reg_write_arbiter #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wbValid,
  input  logic [4:0]               wbRpoint,
  input  logic [31:0]              wbData,
  input  logic                     mdValid,
  input  logic [4:0]               mdRpoint,
  input  logic [31:0]              mdData,
  output logic                     mdReady,
  input  logic [4:0]               R1point,
  input  logic [4:0]               R2point,
  output logic                     R1pending,
  output logic                     R2pending,
  output logic [4:0]               writeRpoint,
  output logic [31:0]              writeData,
  output logic                     writeEnable,
  output logic                     stallReq,
  output logic [$clog2(DEPTH):0]   pendingCount
);

  localparam int                c_PW         = $clog2(DEPTH);
  localparam int                c_SW         = $clog2(STARVE_LIMIT + 1);
  localparam logic [c_PW-1:0]   c_PTR_ONE    = c_PW'(1);
  localparam logic [c_SW-1:0]   c_STARVE_MAX = c_SW'(STARVE_LIMIT);
  localparam logic [c_SW-1:0]   c_STARVE_ONE = c_SW'(1);

  logic [4:0]       r_mem_rp   [DEPTH];
  logic [31:0]      r_mem_data [DEPTH];
  logic [c_PW-1:0]  r_head;
  logic [c_PW-1:0]  r_tail;
  logic [c_PW:0]    r_count;
  logic [c_SW-1:0]  r_starve;
  logic             r_stall;
  logic             r_we;
  logic [4:0]       r_wrp;
  logic [31:0]      r_wdata;

  logic             w_empty;
  logic             w_full;
  logic             w_md_take;
  logic             w_pop;
  logic             w_push;
  logic             w_grant;
  logic [4:0]       w_grant_rp;
  logic [31:0]      w_grant_data;

  assign w_empty   = (r_count == '0);
  assign w_full    = r_count[c_PW];     // count never exceeds DEPTH, a power of two
  assign mdReady   = !rst && (!w_full || (w_empty && !wbValid));
  assign w_md_take = mdValid && mdReady;
  assign w_pop     = !wbValid && !w_empty;
  // An accepted result bypasses the FIFO only when the port is otherwise idle
  assign w_push    = w_md_take && !(w_empty && !wbValid);

  always_comb begin
    w_grant      = 1'b0;
    w_grant_rp   = '0;
    w_grant_data = '0;
    if (wbValid) begin
      w_grant      = 1'b1;
      w_grant_rp   = wbRpoint;
      w_grant_data = wbData;
    end else if (!w_empty) begin
      w_grant      = 1'b1;
      w_grant_rp   = r_mem_rp[r_head];
      w_grant_data = r_mem_data[r_head];
    end else if (w_md_take) begin
      w_grant      = 1'b1;
      w_grant_rp   = mdRpoint;
      w_grant_data = mdData;
    end
  end

  always_comb begin
    logic [c_PW-1:0] w_offset;
    logic            w_valid;
    R1pending = 1'b0;
    R2pending = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      w_offset = c_PW'(i) - r_head;
      w_valid  = ({1'b0, w_offset} < r_count);
      if (w_valid && (R1point != '0) && (r_mem_rp[i] == R1point)) R1pending = 1'b1;
      if (w_valid && (R2point != '0) && (r_mem_rp[i] == R2point)) R2pending = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_rp[r_tail]   <= mdRpoint;
      r_mem_data[r_tail] <= mdData;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head   <= '0;
      r_tail   <= '0;
      r_count  <= '0;
      r_starve <= '0;
      r_stall  <= 1'b0;
      r_we     <= 1'b0;
      r_wrp    <= '0;
      r_wdata  <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + c_PTR_ONE;
      if (w_pop)  r_head <= r_head + c_PTR_ONE;
      r_count <= r_count + {{c_PW{1'b0}}, w_push} - {{c_PW{1'b0}}, w_pop};

      if (w_empty || !wbValid)
        r_starve <= '0;
      else if (r_starve != c_STARVE_MAX)
        r_starve <= r_starve + c_STARVE_ONE;
      r_stall <= (r_starve == c_STARVE_MAX) && !w_pop;

      // Writes to $0 still consume their slot but never reach the register file
      if (w_grant) begin
        r_we    <= (w_grant_rp != '0);
        r_wrp   <= w_grant_rp;
        r_wdata <= w_grant_data;
      end else begin
        r_we    <= 1'b0;
      end
    end
  end

  assign writeEnable  = r_we;
  assign writeRpoint  = r_wrp;
  assign writeData    = r_wdata;
  assign stallReq     = r_stall;
  assign pendingCount = r_count;

endmodule
`default_nettype wire

// File: tb/tb_reg_write_arbiter.sv
`default_nettype none
// ============================================================================
// tb_reg_write_arbiter : vector table, directed corner sequences and a
//                        queue-based reference model for reg_write_arbiter
// Revision: 1.0
// ============================================================================
module tb_reg_write_arbiter;

  localparam int DEPTH        = 2;
  localparam int STARVE_LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        wbValid, mdValid, mdReady;
  logic [4:0]  wbRpoint, mdRpoint, R1point, R2point, writeRpoint;
  logic [31:0] wbData, mdData, writeData;
  logic        R1pending, R2pending, writeEnable, stallReq;
  logic [$clog2(DEPTH):0] pendingCount;

  reg_write_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk(clk), .rst(rst),
    .wbValid(wbValid), .wbRpoint(wbRpoint), .wbData(wbData),
    .mdValid(mdValid), .mdRpoint(mdRpoint), .mdData(mdData), .mdReady(mdReady),
    .R1point(R1point), .R2point(R2point), .R1pending(R1pending), .R2pending(R2pending),
    .writeRpoint(writeRpoint), .writeData(writeData), .writeEnable(writeEnable),
    .stallReq(stallReq), .pendingCount(pendingCount)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic wb; logic [4:0] wrp; logic [31:0] wd;
    logic md; logic [4:0] mrp; logic [31:0] mdd;
    logic [4:0] src;
    logic e_rdy; logic e_pend; logic e_we; logic [4:0] e_rp; logic [31:0] e_d; int e_cnt;
  } vec_t;

  typedef struct { logic [4:0] rp; logic [31:0] d; } ent_t;
  typedef struct { logic we; logic [4:0] rp; logic [31:0] d; int cnt; logic stall; } exp_t;

  int total = 0;
  int bad   = 0;

  vec_t tbl [11];
  ent_t mq [$];
  exp_t sb [$];
  int          m_starve;
  logic        m_stall;
  logic [4:0]  m_rp;
  logic [31:0] m_d;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic wb, input logic [4:0] wrp, input logic [31:0] wd,
                       input logic md, input logic [4:0] mrp, input logic [31:0] mdd,
                       input logic [4:0] s1, input logic [4:0] s2);
    @(negedge clk);
    wbValid = wb; wbRpoint = wrp; wbData = wd;
    mdValid = md; mdRpoint = mrp; mdData = mdd;
    R1point = s1; R2point = s2;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    mq.delete();
    sb.delete();
    m_starve = 0;
    m_stall  = 1'b0;
    m_rp     = '0;
    m_d      = '0;
  endtask

  // One cycle checked against the reference model; expected write is queued
  // when stimulus is applied and retired after the clock edge.
  task automatic mstep(input logic wb, input logic [4:0] wrp, input logic [31:0] wd,
                       input logic md, input logic [4:0] mrp, input logic [31:0] mdd,
                       input logic [4:0] s1, input logic [4:0] s2);
    int n;
    logic rdy, take, g, pop, p1, p2;
    logic [4:0] grp;
    logic [31:0] gd;
    exp_t e;
    ent_t ent;
    drive(wb, wrp, wd, md, mrp, mdd, s1, s2);
    n   = mq.size();
    rdy = (n != DEPTH) || (n == 0 && !wb);
    p1 = 1'b0; p2 = 1'b0;
    foreach (mq[k]) begin
      if (s1 != 0 && mq[k].rp == s1) p1 = 1'b1;
      if (s2 != 0 && mq[k].rp == s2) p2 = 1'b1;
    end
    chk("m_ready", 32'(mdReady), 32'(rdy));
    chk("m_r1pend", 32'(R1pending), 32'(p1));
    chk("m_r2pend", 32'(R2pending), 32'(p2));
    take = md && rdy;
    pop  = !wb && n > 0;
    g = 1'b0; grp = '0; gd = '0;
    if (wb) begin
      g = 1'b1; grp = wrp; gd = wd;
    end else if (n > 0) begin
      ent = mq.pop_front(); g = 1'b1; grp = ent.rp; gd = ent.d;
    end else if (take) begin
      g = 1'b1; grp = mrp; gd = mdd;
    end
    if (take && !(n == 0 && !wb)) begin
      ent.rp = mrp; ent.d = mdd;
      mq.push_back(ent);
    end
    m_stall = (m_starve == STARVE_LIMIT) && !pop;
    if (n == 0 || !wb) m_starve = 0;
    else if (m_starve < STARVE_LIMIT) m_starve++;
    if (g) begin m_rp = grp; m_d = gd; end
    e.we = g && (grp != 0); e.rp = m_rp; e.d = m_d; e.cnt = mq.size(); e.stall = m_stall;
    sb.push_back(e);
    tick();
    e = sb.pop_front();
    chk("m_we", 32'(writeEnable), 32'(e.we));
    chk("m_rp", 32'(writeRpoint), 32'(e.rp));
    chk("m_data", writeData, e.d);
    chk("m_cnt", 32'(pendingCount), 32'(e.cnt));
    chk("m_stall", 32'(stallReq), 32'(e.stall));
  endtask

  initial begin
    //          wb wrp wd           md mrp mdd          src rdy pend we rp  d            cnt
    tbl[0]  = '{1, 5,  32'h1234,    0, 0,  32'h0,       0,  1,  0,   1, 5,  32'h1234,    0};
    tbl[1]  = '{1, 3,  32'h33,      1, 7,  32'hAA,      7,  1,  0,   1, 3,  32'h33,      1};
    tbl[2]  = '{0, 0,  32'h0,       0, 0,  32'h0,       7,  1,  1,   1, 7,  32'hAA,      0};
    tbl[3]  = '{0, 0,  32'h0,       1, 0,  32'h55,      0,  1,  0,   0, 0,  32'h0,       0};
    tbl[4]  = '{0, 0,  32'h0,       0, 0,  32'h0,       7,  1,  0,   0, 0,  32'h0,       0};
    tbl[5]  = '{1, 1,  32'h11,      1, 8,  32'h88,      8,  1,  0,   1, 1,  32'h11,      1};
    tbl[6]  = '{1, 2,  32'h22,      1, 9,  32'h99,      8,  1,  1,   1, 2,  32'h22,      2};
    tbl[7]  = '{0, 0,  32'h0,       1, 10, 32'hA0,      9,  0,  1,   1, 8,  32'h88,      1};
    tbl[8]  = '{0, 0,  32'h0,       1, 10, 32'hA0,      9,  1,  1,   1, 9,  32'h99,      1};
    tbl[9]  = '{0, 0,  32'h0,       0, 0,  32'h0,       10, 1,  1,   1, 10, 32'hA0,      0};
    tbl[10] = '{0, 0,  32'h0,       1, 11, 32'hB1,      11, 1,  0,   1, 11, 32'hB1,      0};

    rst = 1'b1;
    wbValid = 1'b0; wbRpoint = '0; wbData = '0;
    mdValid = 1'b1; mdRpoint = 5'd4; mdData = 32'h1;
    R1point = 5'd0; R2point = 5'd0;
    #12;
    chk("rst_we", 32'(writeEnable), 32'd0);
    chk("rst_rp", 32'(writeRpoint), 32'd0);
    chk("rst_data", writeData, 32'd0);
    chk("rst_stall", 32'(stallReq), 32'd0);
    chk("rst_cnt", 32'(pendingCount), 32'd0);
    chk("rst_ready", 32'(mdReady), 32'd0);
    chk("rst_pend", 32'(R1pending), 32'd0);
    @(negedge clk);
    mdValid = 1'b0;
    rst = 1'b0;

    for (int i = 0; i < 11; i++) begin
      drive(tbl[i].wb, tbl[i].wrp, tbl[i].wd, tbl[i].md, tbl[i].mrp, tbl[i].mdd,
            tbl[i].src, tbl[i].src);
      chk($sformatf("v%0d_ready", i), 32'(mdReady), 32'(tbl[i].e_rdy));
      chk($sformatf("v%0d_r1pend", i), 32'(R1pending), 32'(tbl[i].e_pend));
      chk($sformatf("v%0d_r2pend", i), 32'(R2pending), 32'(tbl[i].e_pend));
      tick();
      chk($sformatf("v%0d_we", i), 32'(writeEnable), 32'(tbl[i].e_we));
      if (tbl[i].e_we) begin
        chk($sformatf("v%0d_rp", i), 32'(writeRpoint), 32'(tbl[i].e_rp));
        chk($sformatf("v%0d_data", i), writeData, tbl[i].e_d);
      end
      chk($sformatf("v%0d_cnt", i), 32'(pendingCount), 32'(tbl[i].e_cnt));
    end

    // Mid-cycle reset with two buffered entries
    drive(1, 1, 32'h1, 1, 20, 32'hD0, 0, 0); tick();
    drive(1, 2, 32'h2, 1, 21, 32'hD1, 0, 0); tick();
    chk("rs_cnt_full", 32'(pendingCount), 32'd2);
    drive(0, 0, 32'h0, 0, 0, 32'h0, 20, 21);
    #2 rst = 1'b1;
    #1;
    chk("rs_we", 32'(writeEnable), 32'd0);
    chk("rs_rp", 32'(writeRpoint), 32'd0);
    chk("rs_data", writeData, 32'd0);
    chk("rs_cnt", 32'(pendingCount), 32'd0);
    chk("rs_ready", 32'(mdReady), 32'd0);
    chk("rs_pend", 32'(R1pending | R2pending), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("rs_idle%0d_we", k), 32'(writeEnable), 32'd0);
      chk($sformatf("rs_idle%0d_cnt", k), 32'(pendingCount), 32'd0);
    end
    drive(1, 6, 32'h66, 0, 0, 32'h0, 0, 0); tick();
    chk("rs_first_we", 32'(writeEnable), 32'd1);
    chk("rs_first_rp", 32'(writeRpoint), 32'd6);

    // Starvation with write-back held high
    drive(1, 1, 32'h11, 1, 12, 32'hC12, 0, 0);
    chk("st_rdy1", 32'(mdReady), 32'd1);
    tick();
    drive(1, 2, 32'h22, 1, 13, 32'hC13, 0, 0);
    chk("st_rdy2", 32'(mdReady), 32'd1);
    tick();
    drive(1, 3, 32'h33, 1, 14, 32'hC14, 0, 0);
    chk("st_rdy3", 32'(mdReady), 32'd0);
    tick();
    chk("st_cnt", 32'(pendingCount), 32'd2);
    chk("st_stall3", 32'(stallReq), 32'd0);
    for (int k = 4; k <= 7; k++) begin
      drive(1, 4, 32'h44, 0, 0, 32'h0, 0, 0);
      tick();
      chk($sformatf("st_stall%0d", k), 32'(stallReq), 32'(k >= 6));
    end
    drive(0, 0, 32'h0, 1, 15, 32'hF15, 13, 12);
    chk("st_pop_ready", 32'(mdReady), 32'd0);
    chk("st_pend13", 32'(R1pending), 32'd1);
    tick();
    chk("st_pop_rp", 32'(writeRpoint), 32'd12);
    chk("st_pop_data", writeData, 32'hC12);
    chk("st_pop_cnt", 32'(pendingCount), 32'd1);
    chk("st_pop_stall", 32'(stallReq), 32'd0);
    drive(0, 0, 32'h0, 1, 15, 32'hF15, 12, 0);
    chk("st_rdy_after", 32'(mdReady), 32'd1);
    chk("st_pend12_gone", 32'(R1pending), 32'd0);
    tick();
    chk("st_pop2_rp", 32'(writeRpoint), 32'd13);
    chk("st_pop2_cnt", 32'(pendingCount), 32'd1);
    drive(0, 0, 32'h0, 0, 0, 32'h0, 15, 0); tick();
    chk("st_last_rp", 32'(writeRpoint), 32'd15);
    chk("st_last_data", writeData, 32'hF15);
    chk("st_last_cnt", 32'(pendingCount), 32'd0);

    // Random traffic against the reference model
    @(negedge clk);
    rst = 1'b1;
    #2;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 300; k++) begin
      mstep(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom(),
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom(),
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/reg_write_arbiter.md
REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

Interface
REQ-001 SHALL have parameter DEPTH, default 2: deferred-write buffer entries; power of two, at least 2.
REQ-002 SHALL have parameter STARVE_LIMIT, default 4: cycles a buffered write may wait before stallReq asserts.
REQ-003 SHALL use a single clock and an asynchronous, active-high reset.
REQ-004 clk  in  1  clock; all state updates on posedge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 wbValid  in  1  pipeline write-back request; cannot be stalled by this block.
REQ-007 wbRpoint  in  5  write-back destination register.
REQ-008 wbData  in  32  write-back data.
REQ-009 mdValid  in  1  multi-cycle mul/div result request.
REQ-010 mdRpoint  in  5  mul/div destination register.
REQ-011 mdData  in  32  mul/div result data.
REQ-012 mdReady  out  1  mul/div result accepted this cycle when high with mdValid.
REQ-013 R1point, R2point  in  5 each  decode-stage source registers for pending lookup.
REQ-014 R1pending, R2pending  out  1 each  source matches a buffered, not-yet-written destination.
REQ-015 writeRpoint  out  5  register-file write address, registered.
REQ-016 writeData  out  32  register-file write data, registered.
REQ-017 writeEnable  out  1  register-file write enable, registered.
REQ-018 stallReq  out  1  request for the pipeline to insert one write-back bubble.
REQ-019 pendingCount  out  log2(DEPTH)+1  buffered entry count.

Function
REQ-020 Write port SHALL be registered: the grant decided at posedge N drives writeEnable/writeRpoint/writeData through cycle N, so the register file commits on that cycle's negedge.
REQ-021 Priority each cycle: wbValid highest; else buffer head; else direct mdValid bypass (empty buffer only).
REQ-022 mdReady SHALL equal (buffer not full) OR (buffer empty AND NOT wbValid); combinational, low in reset.
REQ-023 mdValid with mdReady and wbValid high: mul/div result enqueued at tail.
REQ-024 mdValid with mdReady, wbValid low, buffer empty: result written directly, not enqueued.
REQ-025 mdValid with mdReady, wbValid low, buffer non-empty: head popped and written; new result enqueued same cycle.
REQ-026 Buffer full and head popped same cycle: mdReady SHALL stay low that cycle (no simultaneous push at full).
REQ-027 Buffer SHALL be in-order FIFO; pointers wrap modulo DEPTH; count never exceeds DEPTH or underflows.
REQ-028 Any granted write with destination 0 SHALL drive writeEnable=0 (register $0 immutable); the entry is still consumed.
REQ-029 R1pending/R2pending: combinational match of source against every valid buffered destination; source 0 never pending.
REQ-030 Starve counter: increments each cycle the buffer is non-empty and wbValid is high; clears on any pop or when buffer empty; saturates at STARVE_LIMIT.
REQ-031 stallReq SHALL be registered, asserting the cycle after the counter reaches STARVE_LIMIT and clearing the cycle after the next pop.
REQ-032 No idle cycle: writeEnable low, writeRpoint and writeData hold their previous values.

Reset
REQ-033 While rst high: writeEnable=0, writeRpoint=0, writeData=0, stallReq=0, pendingCount=0, mdReady=0, R1pending=R2pending=0, buffer empty, counter 0.
REQ-034 Reset asserted mid-operation SHALL discard all buffered writes immediately; no write issues after rst deasserts until a new request arrives.
REQ-035 First posedge after rst deassertion SHALL arbitrate normally.

Verification
REQ-036 wbValid only, wbRpoint=5, wbData=0x1234 -> next cycle writeEnable=1, writeRpoint=5, writeData=0x1234; pendingCount=0.
REQ-037 wbValid (r3) and mdValid (r7, 0xAA) same cycle -> r3 written first, pendingCount=1, R1pending=1 for R1point=7; next idle cycle writes r7=0xAA, pendingCount=0.
REQ-038 wbValid held high, mdValid three times with DEPTH=2 -> third request sees mdReady=0; pendingCount=2; stallReq=1 after 4 starved cycles; one wbValid-low cycle pops head.
REQ-039 mdValid with mdRpoint=0, empty buffer -> writeEnable=0, mdReady=1, pendingCount stays 0; R1point=0 never pending.
REQ-040 Buffer holding 2 entries, rst pulsed between clock edges -> outputs zero immediately, pendingCount=0, no write of old entries after release.
REQ-041 Full buffer, wbValid low, mdValid high -> head written, mdReady=0 that cycle, pendingCount=1; next cycle mdReady=1 and result accepted.
